// File: rtl/exc_pkg.sv
// Shared definitions for the exception unit: ExcCode values, vector offsets
// and the handshake state encoding.
package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] VEC_OFF_REFILL  = 32'h0000_0000;
  localparam logic [31:0] VEC_OFF_GENERAL = 32'h0000_0180;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HANDLER = 2'd2
  } exc_state_e;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for the asynchronous level-sensitive interrupt lines.
module irq_sync #(
  parameter int unsigned NUM_IRQ     = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [NUM_IRQ-1:0] irq_sync_o
);

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_i};
    end
  end

  assign irq_sync_o = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/exception_unit.sv
// Exception/interrupt unit: prioritises events at commit, registers cause,
// vector and EPC, and runs the flush handshake until ERET.
module exception_unit
  import exc_pkg::*;
#(
  parameter int unsigned NUM_IRQ      = 6,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] BEV_BASE     = 32'hBFC00200,
  parameter logic [31:0] NORM_BASE    = 32'h80000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               status_ie_i,
  input  logic               status_exl_i,
  input  logic               status_bev_i,
  input  logic [NUM_IRQ-1:0] status_im_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               commit_valid_i,
  input  logic [31:0]        commit_pc_i,
  input  logic               commit_bd_i,
  input  logic               exc_adel_if_i,
  input  logic               exc_ri_i,
  input  logic               exc_sys_i,
  input  logic               exc_bp_i,
  input  logic               exc_ov_i,
  input  logic               exc_adel_i,
  input  logic               exc_ades_i,
  input  logic               tlb_refill_i,
  input  logic               tlb_invalid_i,
  input  logic               tlb_mod_i,
  input  logic               tlb_store_i,
  input  logic               flush_ack_i,
  input  logic               eret_i,
  output logic               exception_occur_o,
  output logic [4:0]         exception_code_o,
  output logic [31:0]        vector_addr_o,
  output logic [31:0]        epc_o,
  output logic               epc_we_o,
  output logic               bd_o,
  output logic               exl_set_o,
  output logic [NUM_IRQ-1:0] cause_ip_o,
  output logic               busy_o,
  output exc_state_e         dbg_state_o
);

  // Handshake: exception_occur_o is a request held high in REQ; the pipeline
  // answers with flush_ack_i, and the request drops on the edge that samples it.

  exc_state_e   r_state;
  logic         r_occur;
  logic [4:0]   r_code;
  logic [31:0]  r_vector;
  logic [31:0]  r_epc;
  logic         r_epc_we;
  logic         r_bd;
  logic         r_exl_set;

  logic [NUM_IRQ-1:0] w_ip;
  logic         w_int_ok;
  logic         w_sync_exc;
  logic         w_take;
  logic         w_refill_win;
  logic [4:0]   w_code;
  logic [4:0]   w_tlb_code;
  logic [31:0]  w_base;
  logic [31:0]  w_vector;
  logic [31:0]  w_epc;

  irq_sync #(
    .NUM_IRQ    (NUM_IRQ),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clk       (clk),
    .rst       (rst),
    .irq_i     (irq_i),
    .irq_sync_o(w_ip)
  );

  always_comb begin
    w_int_ok     = (r_state == ST_IDLE) && (|(w_ip & status_im_i)) &&
                   status_ie_i && !status_exl_i;
    w_sync_exc   = exc_adel_if_i | tlb_refill_i | tlb_invalid_i | exc_ri_i |
                   exc_sys_i | exc_bp_i | exc_ov_i | exc_adel_i | exc_ades_i |
                   tlb_mod_i;
    w_take       = commit_valid_i && (r_state != ST_REQ) && (w_int_ok || w_sync_exc);
    w_tlb_code   = tlb_store_i ? EXC_TLBS : EXC_TLBL;
    w_refill_win = 1'b0;
    w_code       = EXC_INT;
    if (w_int_ok)           w_code = EXC_INT;
    else if (exc_adel_if_i) w_code = EXC_ADEL;
    else if (tlb_refill_i) begin
      w_code       = w_tlb_code;
      w_refill_win = 1'b1;
    end
    else if (tlb_invalid_i) w_code = w_tlb_code;
    else if (exc_ri_i)      w_code = EXC_RI;
    else if (exc_sys_i)     w_code = EXC_SYS;
    else if (exc_bp_i)      w_code = EXC_BP;
    else if (exc_ov_i)      w_code = EXC_OV;
    else if (exc_adel_i)    w_code = EXC_ADEL;
    else if (exc_ades_i)    w_code = EXC_ADES;
    else if (tlb_mod_i)     w_code = EXC_MOD;
    w_base   = status_bev_i ? BEV_BASE : NORM_BASE;
    // Only a first-level refill uses the dedicated refill slot.
    w_vector = w_base + ((w_refill_win && !status_exl_i) ? VEC_OFF_REFILL : VEC_OFF_GENERAL);
    w_epc    = commit_bd_i ? (commit_pc_i - 32'd4) : commit_pc_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_occur   <= 1'b0;
      r_code    <= 5'd0;
      r_vector  <= RESET_VECTOR;
      r_epc     <= 32'd0;
      r_epc_we  <= 1'b0;
      r_bd      <= 1'b0;
      r_exl_set <= 1'b0;
    end else begin
      r_epc_we  <= 1'b0;
      r_exl_set <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HANDLER: begin
          if (w_take) begin
            r_state  <= ST_REQ;
            r_occur  <= 1'b1;
            r_code   <= w_code;
            r_vector <= w_vector;
            // A nested exception keeps the outer EPC and BD.
            if (!status_exl_i) begin
              r_epc     <= w_epc;
              r_bd      <= commit_bd_i;
              r_epc_we  <= 1'b1;
              r_exl_set <= 1'b1;
            end
          end else if ((r_state == ST_HANDLER) && eret_i) begin
            r_state  <= ST_IDLE;
            r_vector <= RESET_VECTOR;
          end
        end
        ST_REQ: begin
          if (flush_ack_i) begin
            r_state <= ST_HANDLER;
            r_occur <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_occur <= 1'b0;
        end
      endcase
    end
  end

  assign exception_occur_o = r_occur;
  assign exception_code_o  = r_code;
  assign vector_addr_o     = r_vector;
  assign epc_o             = r_epc;
  assign epc_we_o          = r_epc_we;
  assign bd_o              = r_bd;
  assign exl_set_o         = r_exl_set;
  assign cause_ip_o        = w_ip;
  assign busy_o            = (r_state != ST_IDLE);
  assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_exception_unit.sv
// Directed and randomised checks of exception_unit against a priority-list model.
module tb_exception_unit;
  import exc_pkg::*;

  localparam int NI = 6;
  localparam int SS = 2;
  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [31:0] BB = 32'hBFC00200;
  localparam logic [31:0] NB = 32'h80000000;

  logic clk, rst;
  logic status_ie_i, status_exl_i, status_bev_i;
  logic [NI-1:0] status_im_i, irq_i;
  logic commit_valid_i, commit_bd_i;
  logic [31:0] commit_pc_i;
  logic exc_adel_if_i, exc_ri_i, exc_sys_i, exc_bp_i, exc_ov_i, exc_adel_i, exc_ades_i;
  logic tlb_refill_i, tlb_invalid_i, tlb_mod_i, tlb_store_i;
  logic flush_ack_i, eret_i;
  logic exception_occur_o, epc_we_o, bd_o, exl_set_o, busy_o;
  logic [4:0] exception_code_o;
  logic [31:0] vector_addr_o, epc_o;
  logic [NI-1:0] cause_ip_o;
  exc_state_e dbg_state_o;

  exception_unit #(
    .NUM_IRQ(NI), .SYNC_STAGES(SS), .RESET_VECTOR(RV), .BEV_BASE(BB), .NORM_BASE(NB)
  ) dut (
    .clk(clk), .rst(rst),
    .status_ie_i(status_ie_i), .status_exl_i(status_exl_i), .status_bev_i(status_bev_i),
    .status_im_i(status_im_i), .irq_i(irq_i),
    .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i), .commit_bd_i(commit_bd_i),
    .exc_adel_if_i(exc_adel_if_i), .exc_ri_i(exc_ri_i), .exc_sys_i(exc_sys_i),
    .exc_bp_i(exc_bp_i), .exc_ov_i(exc_ov_i), .exc_adel_i(exc_adel_i), .exc_ades_i(exc_ades_i),
    .tlb_refill_i(tlb_refill_i), .tlb_invalid_i(tlb_invalid_i), .tlb_mod_i(tlb_mod_i),
    .tlb_store_i(tlb_store_i), .flush_ack_i(flush_ack_i), .eret_i(eret_i),
    .exception_occur_o(exception_occur_o), .exception_code_o(exception_code_o),
    .vector_addr_o(vector_addr_o), .epc_o(epc_o), .epc_we_o(epc_we_o), .bd_o(bd_o),
    .exl_set_o(exl_set_o), .cause_ip_o(cause_ip_o), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic clear_flags();
    commit_valid_i = 1'b0; commit_bd_i = 1'b0;
    exc_adel_if_i = 1'b0; exc_ri_i = 1'b0; exc_sys_i = 1'b0; exc_bp_i = 1'b0;
    exc_ov_i = 1'b0; exc_adel_i = 1'b0; exc_ades_i = 1'b0;
    tlb_refill_i = 1'b0; tlb_invalid_i = 1'b0; tlb_mod_i = 1'b0; tlb_store_i = 1'b0;
    flush_ack_i = 1'b0; eret_i = 1'b0;
  endtask

  task automatic fire(input logic [31:0] pc, input logic bd);
    commit_pc_i = pc; commit_bd_i = bd; commit_valid_i = 1'b1;
    tick();
    clear_flags();
  endtask

  task automatic ack();
    flush_ack_i = 1'b1; tick(); flush_ack_i = 1'b0;
  endtask

  task automatic do_eret();
    eret_i = 1'b1; tick(); eret_i = 1'b0;
  endtask

  // Reference model: spec priority list walked in order
  typedef struct { logic act; logic [4:0] code; logic refill; } ev_t;

  function automatic void ref_pick(input logic int_ok, output logic found,
                                   output logic [4:0] code, output logic refill);
    ev_t evs[11];
    logic [4:0] tc;
    tc = tlb_store_i ? 5'd3 : 5'd2;
    evs[0]  = '{int_ok,        5'd0,  1'b0};
    evs[1]  = '{exc_adel_if_i, 5'd4,  1'b0};
    evs[2]  = '{tlb_refill_i,  tc,    1'b1};
    evs[3]  = '{tlb_invalid_i, tc,    1'b0};
    evs[4]  = '{exc_ri_i,      5'd10, 1'b0};
    evs[5]  = '{exc_sys_i,     5'd8,  1'b0};
    evs[6]  = '{exc_bp_i,      5'd9,  1'b0};
    evs[7]  = '{exc_ov_i,      5'd12, 1'b0};
    evs[8]  = '{exc_adel_i,    5'd4,  1'b0};
    evs[9]  = '{exc_ades_i,    5'd5,  1'b0};
    evs[10] = '{tlb_mod_i,     5'd1,  1'b0};
    found = 1'b0; code = 5'd0; refill = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (!found && evs[i].act) begin
        found = 1'b1; code = evs[i].code; refill = evs[i].refill;
      end
    end
  endfunction

  localparam int M_IDLE = 0, M_REQ = 1, M_HND = 2;
  int          m_mode;
  logic        m_occur, m_we, m_exl, m_bd;
  logic [4:0]  m_code;
  logic [31:0] m_vec, m_epc;
  logic [NI-1:0] m_ip;
  logic [NI-1:0] hist[$];

  function automatic bit rb(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  initial begin
    logic found, refill;
    logic [4:0] c;
    logic int_ok;
    clear_flags();
    status_ie_i = 1'b0; status_exl_i = 1'b0; status_bev_i = 1'b1;
    status_im_i = '0; irq_i = '0; commit_pc_i = 32'd0;

    // Reset
    rst = 1'b1;
    repeat (3) tick();
    check("rst_vector", vector_addr_o, RV);
    check("rst_occur", 32'(exception_occur_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_epc", epc_o, 32'd0);
    check("rst_code", 32'(exception_code_o), 32'd0);
    rst = 1'b0;

    // Interrupt through the synchroniser
    status_im_i = 6'b000100; status_ie_i = 1'b1; irq_i = 6'b000100;
    commit_valid_i = 1'b1; commit_pc_i = 32'h80001000;
    tick();
    check("irq_occ_s1", 32'(exception_occur_o), 32'd0);
    tick();
    check("irq_ip", 32'(cause_ip_o), 32'(6'b000100));
    check("irq_occ_s2", 32'(exception_occur_o), 32'd0);
    tick();
    clear_flags(); irq_i = '0; status_ie_i = 1'b0; status_im_i = '0;
    check("irq_occ", 32'(exception_occur_o), 32'd1);
    check("irq_code", 32'(exception_code_o), 32'd0);
    check("irq_vec", vector_addr_o, 32'hBFC00380);
    check("irq_epc", epc_o, 32'h80001000);
    check("irq_exl", 32'(exl_set_o), 32'd1);
    check("irq_we", 32'(epc_we_o), 32'd1);
    ack();
    check("irq_exl_pulse", 32'(exl_set_o), 32'd0);
    check("irq_ack_occ", 32'(exception_occur_o), 32'd0);
    check("irq_hnd_busy", 32'(busy_o), 32'd1);
    do_eret();
    check("eret_busy", 32'(busy_o), 32'd0);
    check("eret_vec", vector_addr_o, RV);
    tick();

    // Delay-slot overflow
    status_bev_i = 1'b0;
    exc_ov_i = 1'b1;
    fire(32'h80002004, 1'b1);
    check("ov_code", 32'(exception_code_o), 32'd12);
    check("ov_vec", vector_addr_o, 32'h80000180);
    check("ov_epc", epc_o, 32'h80002000);
    check("ov_bd", 32'(bd_o), 32'd1);
    ack(); do_eret();

    // TLB refill, first-level then nested
    tlb_refill_i = 1'b1; tlb_store_i = 1'b1;
    fire(32'h80003000, 1'b0);
    check("refill_code", 32'(exception_code_o), 32'd3);
    check("refill_vec", vector_addr_o, 32'h80000000);
    check("refill_bd", 32'(bd_o), 32'd0);
    ack(); do_eret();
    status_exl_i = 1'b1;
    tlb_refill_i = 1'b1; tlb_store_i = 1'b1;
    fire(32'h80004000, 1'b0);
    check("nest_vec", vector_addr_o, 32'h80000180);
    check("nest_we", 32'(epc_we_o), 32'd0);
    check("nest_exl", 32'(exl_set_o), 32'd0);
    check("nest_epc", epc_o, 32'h80003000);
    ack(); do_eret();
    status_exl_i = 1'b0;

    // Priority among synchronous exceptions, then with an interrupt pending
    exc_ri_i = 1'b1; exc_sys_i = 1'b1; exc_ov_i = 1'b1;
    fire(32'h80005000, 1'b0);
    check("prio_code", 32'(exception_code_o), 32'd10);
    ack(); do_eret();
    status_ie_i = 1'b1; status_im_i = 6'b000001; irq_i = 6'b000001;
    tick(); tick();
    exc_ri_i = 1'b1; exc_sys_i = 1'b1; exc_ov_i = 1'b1;
    fire(32'h80005100, 1'b0);
    check("prio_int_code", 32'(exception_code_o), 32'd0);
    irq_i = '0; status_ie_i = 1'b0; status_im_i = '0;
    ack(); do_eret();
    tick(); tick();

    // Delayed flush acknowledge keeps the request stable
    exc_sys_i = 1'b1;
    fire(32'h80006000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_occ", 32'(exception_occur_o), 32'd1);
      check("hold_code", 32'(exception_code_o), 32'd8);
      check("hold_vec", vector_addr_o, 32'h80000180);
      check("hold_epc", epc_o, 32'h80006000);
    end
    ack();
    check("hold_drop", 32'(exception_occur_o), 32'd0);
    check("hnd_state", 32'(dbg_state_o), 32'(ST_HANDLER));

    // Interrupts ignored in the handler
    status_ie_i = 1'b1; status_im_i = '1; irq_i = '1; commit_valid_i = 1'b1;
    repeat (3) tick();
    check("hnd_irq_occ", 32'(exception_occur_o), 32'd0);
    check("hnd_irq_busy", 32'(busy_o), 32'd1);
    eret_i = 1'b1; tick();
    clear_flags(); irq_i = '0; status_ie_i = 1'b0; status_im_i = '0;
    check("hnd_eret_idle", 32'(dbg_state_o), 32'(ST_IDLE));
    tick(); tick();
    check("idle_after", 32'(exception_occur_o), 32'd0);

    // ERET and a syscall in the same cycle: the exception wins
    exc_bp_i = 1'b1;
    fire(32'h80007000, 1'b0);
    ack();
    exc_sys_i = 1'b1; eret_i = 1'b1;
    fire(32'h80007100, 1'b0);
    check("eret_sys_occ", 32'(exception_occur_o), 32'd1);
    check("eret_sys_code", 32'(exception_code_o), 32'd8);

    // Reset in REQ
    rst = 1'b1; tick(); rst = 1'b0;
    check("rreq_occ", 32'(exception_occur_o), 32'd0);
    check("rreq_vec", vector_addr_o, RV);
    check("rreq_epc", epc_o, 32'd0);
    check("rreq_code", 32'(exception_code_o), 32'd0);
    check("rreq_busy", 32'(busy_o), 32'd0);
    check("rreq_bd", 32'(bd_o), 32'd0);

    // Randomised run against the model
    irq_i = '0; rst = 1'b1; tick(); rst = 1'b0;
    m_mode = M_IDLE; m_occur = 0; m_we = 0; m_exl = 0; m_bd = 0;
    m_code = 5'd0; m_vec = RV; m_epc = 32'd0; m_ip = '0;
    hist.delete();
    for (int it = 0; it < 400; it++) begin
      status_ie_i = rb(70); status_exl_i = rb(25); status_bev_i = rb(50);
      status_im_i = NI'($urandom);
      if (rb(20)) irq_i = NI'($urandom);
      commit_valid_i = rb(70); commit_bd_i = rb(30);
      commit_pc_i = {$urandom_range(32'hFFFFFFFF, 0)} & 32'hFFFFFFFC;
      exc_adel_if_i = rb(6); exc_ri_i = rb(8); exc_sys_i = rb(8); exc_bp_i = rb(8);
      exc_ov_i = rb(8); exc_adel_i = rb(8); exc_ades_i = rb(8);
      tlb_refill_i = rb(8); tlb_invalid_i = rb(8); tlb_mod_i = rb(8); tlb_store_i = rb(50);
      flush_ack_i = rb(50); eret_i = rb(30);

      m_we = 0; m_exl = 0;
      if (m_mode == M_REQ) begin
        if (flush_ack_i) begin m_mode = M_HND; m_occur = 0; end
      end else begin
        int_ok = (m_mode == M_IDLE) && status_ie_i && !status_exl_i && (|(m_ip & status_im_i));
        ref_pick(int_ok, found, c, refill);
        if (commit_valid_i && found) begin
          m_mode = M_REQ; m_occur = 1; m_code = c;
          m_vec = (status_bev_i ? BB : NB) + ((refill && !status_exl_i) ? 32'h0 : 32'h180);
          if (!status_exl_i) begin
            m_epc = commit_bd_i ? commit_pc_i - 32'd4 : commit_pc_i;
            m_bd = commit_bd_i; m_we = 1; m_exl = 1;
          end
        end else if (m_mode == M_HND && eret_i) begin
          m_mode = M_IDLE; m_vec = RV;
        end
      end
      hist.push_front(irq_i);
      if (hist.size() > SS) void'(hist.pop_back());
      m_ip = (hist.size() == SS) ? hist[SS-1] : '0;

      tick();
      check("r_occ", 32'(exception_occur_o), 32'(m_occur));
      check("r_code", 32'(exception_code_o), 32'(m_code));
      check("r_vec", vector_addr_o, m_vec);
      check("r_epc", epc_o, m_epc);
      check("r_we", 32'(epc_we_o), 32'(m_we));
      check("r_bd", 32'(bd_o), 32'(m_bd));
      check("r_exl", 32'(exl_set_o), 32'(m_exl));
      check("r_ip", 32'(cause_ip_o), 32'(m_ip));
      check("r_busy", 32'(busy_o), 32'(m_mode != M_IDLE));
    end

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
